// File: rtl/mem_stage_pkg.sv
// Shared constants, FSM state type and the EX/MEM capture record for the
// memory-access pipeline stage.
package mem_stage_pkg;

    localparam int DATA_W         = 16;
    localparam int REG_W          = 3;
    localparam int TIMEOUT_CYCLES = 15;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Everything Execute hands over, frozen for the life of one operation.
    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] adder_result;
        logic              zero;
        logic [DATA_W-1:0] store_data;
        logic [REG_W-1:0]  write_reg;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              reg_write;
        logic              mem_to_reg;
    } ex_mem_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the memory-access stage (master) and the
// data memory (slave).
interface mem_access_stage_if;
    import mem_stage_pkg::*;

    logic              dmem_req;
    logic              dmem_we;
    logic [DATA_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic [DATA_W-1:0] dmem_rdata;
    logic              dmem_ack;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_rdata, dmem_ack
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_rdata, dmem_ack
    );

endinterface

// File: rtl/mem_access_stage_ex_mem_reg.sv
// EX/MEM boundary register: captures the Execute record when the stage
// accepts an operation and holds it until the next acceptance.
module ex_mem_reg
    import mem_stage_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    load_en,
    input  ex_mem_t d,
    output ex_mem_t q
);

    // NOTE: the record is cleared asynchronously so the bus address/data
    // outputs it feeds read 0 during reset; it is a register, not a RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load_en) begin
            // NOTE: sequential state always uses non-blocking assignment.
            q <= d;
        end
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: EX/MEM capture, branch resolution, data-memory req/ack
// access and MEM/WB result. Optional access timeout under `MEM_TIMEOUT_EN.
module mem_access_stage
    import mem_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] adder_result,
    input  logic              zero,
    input  logic [DATA_W-1:0] store_data,
    input  logic [REG_W-1:0]  write_reg,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              branch,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    output logic              stall,
    output logic              pc_src,
    output logic [DATA_W-1:0] branch_target,
    mem_access_stage_if.master dmem,
    output logic              wb_valid,
    output logic              wb_reg_write,
    output logic [REG_W-1:0]  wb_write_reg,
    output logic [DATA_W-1:0] wb_data,
    output logic              bus_err
);

    state_t  state_q, state_d;
    ex_mem_t ex_in, ex_q;
    logic    accept, accept_mem, ack_hit, timeout_hit, accepted_q;
    logic    use_rdata;

    assign accept     = (state_q == IDLE) && ex_valid;
    assign accept_mem = accept && (mem_read || mem_write);
    assign ack_hit    = (state_q == ACCESS) && dmem.dmem_ack;

    assign ex_in = '{
        alu_result:   alu_result,
        adder_result: adder_result,
        zero:         zero,
        store_data:   store_data,
        write_reg:    write_reg,
        mem_read:     mem_read,
        mem_write:    mem_write,
        branch:       branch,
        reg_write:    reg_write,
        mem_to_reg:   mem_to_reg
    };

    ex_mem_reg u_ex_mem_reg (
        .clk     (clk),
        .rst     (rst),
        .load_en (accept),
        .d       (ex_in),
        .q       (ex_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and infers a latch.
    always_comb begin
        state_d       = state_q;
        stall         = 1'b0;
        dmem.dmem_req = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept_mem) state_d = ACCESS;
            end
            ACCESS: begin
                stall         = 1'b1;
                dmem.dmem_req = 1'b1;
                if (ack_hit || timeout_hit) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A request with both read and write set is a store.
    assign dmem.dmem_we    = (state_q == ACCESS) && ex_q.mem_write;
    assign dmem.dmem_addr  = ex_q.alu_result;
    assign dmem.dmem_wdata = ex_q.store_data;

    // Branch outcome comes straight from the captured record the cycle after
    // acceptance, whether or not a memory access follows.
    assign pc_src        = accepted_q && ex_q.branch && ex_q.zero;
    assign branch_target = ex_q.adder_result;

    assign use_rdata = !ex_q.mem_write && ex_q.mem_read && ex_q.mem_to_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            accepted_q   <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            wb_write_reg <= '0;
            wb_data      <= '0;
        end else begin
            accepted_q   <= accept;
            wb_valid     <= 1'b0;
            wb_reg_write <= 1'b0;
            if (accept && !accept_mem) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= reg_write;
                wb_write_reg <= write_reg;
                wb_data      <= alu_result;
            end else if (ack_hit) begin
                wb_valid     <= 1'b1;
                wb_reg_write <= !ex_q.mem_write && ex_q.reg_write;
                wb_write_reg <= ex_q.write_reg;
                wb_data      <= use_rdata ? dmem.dmem_rdata : ex_q.alu_result;
            end else if (timeout_hit) begin
                wb_valid <= 1'b1;
            end
        end
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt_q;
    logic             bus_err_q;

    // An ack in the limit cycle wins over the timeout.
    assign timeout_hit = (state_q == ACCESS) && !dmem.dmem_ack &&
                         (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= timeout_hit;
            if (state_q == IDLE)          wait_cnt_q <= '0;
            else if (!dmem.dmem_ack)      wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign bus_err = bus_err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; define MEM_TIMEOUT_EN
// to exercise the timeout build.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    logic              clk;
    logic              rst;
    logic              ex_valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] adder_result;
    logic              zero;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  write_reg;
    logic              mem_read, mem_write, branch, reg_write, mem_to_reg;
    logic              stall, pc_src, wb_valid, wb_reg_write, bus_err;
    logic [DATA_W-1:0] branch_target, wb_data;
    logic [REG_W-1:0]  wb_write_reg;

    int checks = 0;
    int errors = 0;

    mem_access_stage_if dmem_bus ();

    mem_access_stage dut (
        .clk           (clk),
        .rst           (rst),
        .ex_valid      (ex_valid),
        .alu_result    (alu_result),
        .adder_result  (adder_result),
        .zero          (zero),
        .store_data    (store_data),
        .write_reg     (write_reg),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .branch        (branch),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .stall         (stall),
        .pc_src        (pc_src),
        .branch_target (branch_target),
        .dmem          (dmem_bus),
        .wb_valid      (wb_valid),
        .wb_reg_write  (wb_reg_write),
        .wb_write_reg  (wb_write_reg),
        .wb_data       (wb_data),
        .bus_err       (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid     = 1'b0;
        alu_result   = '0;
        adder_result = '0;
        zero         = 1'b0;
        store_data   = '0;
        write_reg    = '0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        branch       = 1'b0;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        dmem_bus.dmem_ack   = 1'b0;
        dmem_bus.dmem_rdata = '0;
        tick();
        tick();

        // Reset state
        check("rst_stall",   stall,             0);
        check("rst_req",     dmem_bus.dmem_req, 0);
        check("rst_addr",    dmem_bus.dmem_addr, 0);
        check("rst_pc_src",  pc_src,            0);
        check("rst_wb_val",  wb_valid,          0);
        check("rst_wb_data", wb_data,           0);
        check("rst_bus_err", bus_err,           0);
        rst = 1'b0;
        tick();

        // ALU pass-through
        ex_valid = 1'b1; alu_result = 16'h1234; write_reg = 3'd5; reg_write = 1'b1;
        check("alu_stall_n", stall, 0);
        tick();
        clear_inputs();
        check("alu_wb_val",  wb_valid,     1);
        check("alu_wb_data", wb_data,      16'h1234);
        check("alu_wb_reg",  wb_write_reg, 5);
        check("alu_wb_we",   wb_reg_write, 1);
        check("alu_stall",   stall,        0);
        tick();
        check("alu_wb_pulse", wb_valid,    0);
        check("alu_wb_we0",   wb_reg_write, 0);
        check("alu_wb_hold",  wb_data,     16'h1234);

        // Ack while idle is ignored
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        check("idle_ack_wb",    wb_valid, 0);
        check("idle_ack_stall", stall,    0);

        // Load with ack on the third request cycle
        ex_valid = 1'b1; alu_result = 16'h0040; mem_read = 1'b1; mem_to_reg = 1'b1;
        reg_write = 1'b1; write_reg = 3'd3;
        tick();
        clear_inputs();
        ex_valid = 1'b1; alu_result = 16'h9999; write_reg = 3'd7; reg_write = 1'b1;
        check("ld_stall1", stall,               1);
        check("ld_req1",   dmem_bus.dmem_req,   1);
        check("ld_we1",    dmem_bus.dmem_we,    0);
        check("ld_addr1",  dmem_bus.dmem_addr,  16'h0040);
        tick();
        check("ld_stall2", stall,               1);
        check("ld_addr2",  dmem_bus.dmem_addr,  16'h0040);
        check("ld_wb2",    wb_valid,            0);
        tick();
        clear_inputs();
        check("ld_stall3", stall,               1);
        check("ld_addr3",  dmem_bus.dmem_addr,  16'h0040);
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 16'hBEEF;
        tick();
        dmem_bus.dmem_ack = 1'b0; dmem_bus.dmem_rdata = '0;
        check("ld_wb_val",  wb_valid,          1);
        check("ld_wb_data", wb_data,           16'hBEEF);
        check("ld_wb_we",   wb_reg_write,      1);
        check("ld_wb_reg",  wb_write_reg,      3);
        check("ld_req_off", dmem_bus.dmem_req, 0);
        check("ld_stall_n", stall,             0);
        tick();
        check("ld_no_extra", wb_valid, 0);
        check("ld_idle",     stall,    0);

        // Store with ack in the first access cycle
        ex_valid = 1'b1; alu_result = 16'h0080; mem_write = 1'b1; store_data = 16'h00AA;
        reg_write = 1'b1; write_reg = 3'd2;
        tick();
        clear_inputs();
        check("st_req",   dmem_bus.dmem_req,   1);
        check("st_we",    dmem_bus.dmem_we,    1);
        check("st_wdata", dmem_bus.dmem_wdata, 16'h00AA);
        check("st_addr",  dmem_bus.dmem_addr,  16'h0080);
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        check("st_wb_val", wb_valid,          1);
        check("st_wb_we",  wb_reg_write,      0);
        check("st_req0",   dmem_bus.dmem_req, 0);
        tick();

        // Branch taken, then not taken
        ex_valid = 1'b1; branch = 1'b1; zero = 1'b1; adder_result = 16'h0100;
        tick();
        clear_inputs();
        check("br_pc_src", pc_src,        1);
        check("br_target", branch_target, 16'h0100);
        tick();
        check("br_pulse", pc_src, 0);
        ex_valid = 1'b1; branch = 1'b1; zero = 1'b0; adder_result = 16'h0104;
        tick();
        clear_inputs();
        check("br_nt", pc_src, 0);
        tick();

        // Branch alongside a load, then reset in the middle of the access
        ex_valid = 1'b1; mem_read = 1'b1; branch = 1'b1; zero = 1'b1;
        adder_result = 16'h0200; alu_result = 16'h0300; reg_write = 1'b1;
        tick();
        clear_inputs();
        check("brm_pc_src", pc_src,            1);
        check("brm_target", branch_target,     16'h0200);
        check("brm_req",    dmem_bus.dmem_req, 1);
        tick();
        check("brm_pulse", pc_src,            0);
        check("brm_req2",  dmem_bus.dmem_req, 1);
        #2 rst = 1'b1;
        #1;
        check("mrst_req",   dmem_bus.dmem_req,  0);
        check("mrst_stall", stall,              0);
        check("mrst_addr",  dmem_bus.dmem_addr, 0);
        check("mrst_wb",    wb_valid,           0);
        tick();
        rst = 1'b0;
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        check("mrst_wb1", wb_valid, 0);
        tick();
        check("mrst_wb2",    wb_valid, 0);
        check("mrst_stall2", stall,    0);

`ifdef MEM_TIMEOUT_EN
        // No ack: request held 15 cycles, then bus_err with a writeback pulse
        ex_valid = 1'b1; alu_result = 16'h0500; mem_read = 1'b1; reg_write = 1'b1;
        tick();
        clear_inputs();
        for (int i = 1; i <= TIMEOUT_CYCLES; i++) begin
            check("to_req",  dmem_bus.dmem_req, 1);
            check("to_berr", bus_err,           0);
            if (i < TIMEOUT_CYCLES) tick();
        end
        tick();
        check("to_bus_err", bus_err,           1);
        check("to_wb_val",  wb_valid,          1);
        check("to_wb_we",   wb_reg_write,      0);
        check("to_req_off", dmem_bus.dmem_req, 0);
        check("to_idle",    stall,             0);
        tick();
        check("to_berr_pulse", bus_err, 0);

        // Ack in the limit cycle completes normally
        ex_valid = 1'b1; alu_result = 16'h0600; mem_read = 1'b1; reg_write = 1'b1;
        write_reg = 3'd4;
        tick();
        clear_inputs();
        for (int i = 1; i < TIMEOUT_CYCLES; i++) tick();
        check("tok_req", dmem_bus.dmem_req, 1);
        dmem_bus.dmem_ack = 1'b1;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        check("tok_berr",  bus_err,      0);
        check("tok_wb",    wb_valid,     1);
        check("tok_wb_we", wb_reg_write, 1);
        check("tok_data",  wb_data,      16'h0600);
        tick();
        check("tok_berr2", bus_err, 0);
`else
        // Without the timeout an unacked access waits indefinitely
        ex_valid = 1'b1; alu_result = 16'h0500; mem_read = 1'b1; reg_write = 1'b1;
        tick();
        clear_inputs();
        for (int i = 0; i < 20; i++) tick();
        check("wait_req",   dmem_bus.dmem_req, 1);
        check("wait_stall", stall,             1);
        check("wait_berr",  bus_err,           0);
        check("wait_wb",    wb_valid,          0);
        dmem_bus.dmem_ack = 1'b1; dmem_bus.dmem_rdata = 16'h1111;
        tick();
        dmem_bus.dmem_ack = 1'b0;
        check("wait_done", wb_valid, 1);
        check("wait_data", wb_data,  16'h0500);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
